// File: rtl/jesd204b_sysref_align.sv
// +----------------------------------------------------------------------------+
// | jesd204b_sysref_align: SYSREF/SYNC~ capture, deglitch and LMFC alignment   |
// | Rev 1.0 - initial parametrised release                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module jesd204b_sysref_align #(
  parameter int N_SYNC      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LMFC_PERIOD = 32,
  parameter int DEGLITCH    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic                           neg_edge_sel,
  input  logic [1:0]                     sysref_mode,
  input  logic                           arm,
  input  logic                           sysref_i,
  input  logic [N_SYNC-1:0]              sync_b_i,
  output logic [N_SYNC-1:0]              sync_b_o,
  output logic                           sysref_o,
  output logic                           lmfc_o,
  output logic [$clog2(LMFC_PERIOD)-1:0] lmfc_phase_o,
  output logic                           aligned_o,
  output logic                           phase_err_o,
  output logic [CNT_W-1:0]               sysref_cnt_o
);

  localparam int PH_W = $clog2(LMFC_PERIOD);
  localparam int CAP_W = N_SYNC + 1;
  localparam int DG_W = $clog2(DEGLITCH + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(LMFC_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ALIGNED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Capture on the selected edge, then a posedge synchroniser chain
  // ---------------------------------------------------------------------------
  logic [CAP_W-1:0] cap_p;
  logic [CAP_W-1:0] cap_n;
  logic [CAP_W-1:0] cap_sel;
  logic [CAP_W-1:0] pipe [SYNC_STAGES];
  logic [CAP_W-1:0] synced;
  logic             sysref_s;
  logic             sysref_s_d;
  logic [N_SYNC-1:0] sync_s;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) cap_p <= '0;
    else          cap_p <= {sync_b_i, sysref_i};
  end

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) cap_n <= '0;
    else          cap_n <= {sync_b_i, sysref_i};
  end

  assign cap_sel = neg_edge_sel ? cap_n : cap_p;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) pipe[g] <= '0;
        else          pipe[g] <= cap_sel;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) pipe[g] <= '0;
        else          pipe[g] <= pipe[g-1];
      end
    end
  end

  assign synced   = pipe[SYNC_STAGES-1];
  assign sysref_s = synced[0];
  assign sync_s   = synced[CAP_W-1:1];

  // ---------------------------------------------------------------------------
  // SYSREF rising-edge pulse and saturating event counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sysref_s_d <= 1'b0;
      sysref_o   <= 1'b0;
    end else begin
      sysref_s_d <= sysref_s;
      sysref_o   <= sysref_s & ~sysref_s_d;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                          sysref_cnt_o <= '0;
    else if (sysref_o && !(&sysref_cnt_o)) sysref_cnt_o <= sysref_cnt_o + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Per-lane SYNC~ deglitch: output follows only after DEGLITCH differing samples
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_SYNC; g++) begin : g_lane
    logic [DG_W-1:0] dg_cnt;
    logic            lane_q;

    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        dg_cnt <= '0;
        lane_q <= 1'b0;
      end else if (sync_s[g] == lane_q) begin
        dg_cnt <= '0;
      end else if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
        dg_cnt <= '0;
        lane_q <= sync_s[g];
      end else begin
        dg_cnt <= dg_cnt + DG_W'(1);
      end
    end

    assign sync_b_o[g] = lane_q;
  end

  // ---------------------------------------------------------------------------
  // Alignment state machine
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   mode_on;
  logic   mode_cont;

  assign mode_on   = (sysref_mode == 2'd1) || (sysref_mode == 2'd2);
  assign mode_cont = (sysref_mode == 2'd2);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!mode_on) begin
      state_nxt = ST_IDLE;
    end else if (arm) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED:   if (sysref_o) state_nxt = ST_ALIGNED;
        ST_ALIGNED: state_nxt = ST_ALIGNED;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // LMFC counter: zero outside ALIGNED, zeroed on entry and on continuous realign
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0] lmfc_cnt;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                                         lmfc_cnt <= '0;
    else if (state_nxt != ST_ALIGNED || state != ST_ALIGNED) lmfc_cnt <= '0;
    else if (mode_cont && sysref_o)                       lmfc_cnt <= '0;
    else if (lmfc_cnt == PH_LAST)                         lmfc_cnt <= '0;
    else                                                  lmfc_cnt <= lmfc_cnt + PH_W'(1);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      phase_err_o <= 1'b0;
    end else if (mode_on && arm) begin
      phase_err_o <= 1'b0;
    end else if (state == ST_ALIGNED && mode_cont && sysref_o && lmfc_cnt != PH_LAST) begin
      phase_err_o <= 1'b1;
    end
  end

  assign aligned_o    = (state == ST_ALIGNED);
  assign lmfc_o       = aligned_o && (lmfc_cnt == '0);
  assign lmfc_phase_o = lmfc_cnt;

endmodule

`default_nettype wire

// File: tb/tb_jesd204b_sysref_align.sv
// +----------------------------------------------------------------------------+
// | tb_jesd204b_sysref_align: random + directed bench against a cycle model    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_jesd204b_sysref_align;

  localparam int N_SYNC      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LMFC_PERIOD = 32;
  localparam int DEGLITCH    = 3;
  localparam int CNT_W       = 2;
  localparam int PH_W        = $clog2(LMFC_PERIOD);
  localparam int MAXC        = 16384;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              neg_edge_sel = 1'b0;
  logic [1:0]        sysref_mode = 2'd0;
  logic              arm = 1'b0;
  logic              sysref_i = 1'b0;
  logic [N_SYNC-1:0] sync_b_i = '1;
  logic [N_SYNC-1:0] sync_b_o;
  logic              sysref_o;
  logic              lmfc_o;
  logic [PH_W-1:0]   lmfc_phase_o;
  logic              aligned_o;
  logic              phase_err_o;
  logic [CNT_W-1:0]  sysref_cnt_o;

  always #5 clk = ~clk;

  jesd204b_sysref_align #(
    .N_SYNC      (N_SYNC),
    .SYNC_STAGES (SYNC_STAGES),
    .LMFC_PERIOD (LMFC_PERIOD),
    .DEGLITCH    (DEGLITCH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .neg_edge_sel (neg_edge_sel),
    .sysref_mode  (sysref_mode),
    .arm          (arm),
    .sysref_i     (sysref_i),
    .sync_b_i     (sync_b_i),
    .sync_b_o     (sync_b_o),
    .sysref_o     (sysref_o),
    .lmfc_o       (lmfc_o),
    .lmfc_phase_o (lmfc_phase_o),
    .aligned_o    (aligned_o),
    .phase_err_o  (phase_err_o),
    .sysref_cnt_o (sysref_cnt_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rel = 0;

  // Input history indexed by the cycle in which each value was held
  logic              vh [MAXC];
  logic [N_SYNC-1:0] sh [MAXC];

  logic              m_so = 1'b0;
  logic              m_perr = 1'b0;
  logic              m_armed = 1'b0;
  logic              m_aligned = 1'b0;
  logic              m_lmfc = 1'b0;
  logic [N_SYNC-1:0] m_sync = '0;
  int                m_cnt = 0;
  int                m_ref = 0;
  int                m_phase = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expd, cyc);
    end
  endtask

  function automatic logic hv(input int j);
    return (j < rel || j < 0) ? 1'b0 : vh[j];
  endfunction

  // Synchronised SYNC~ value seen inside the DUT during cycle c
  function automatic logic [N_SYNC-1:0] ss(input int c);
    int j;
    j = c - (neg_edge_sel ? SYNC_STAGES : SYNC_STAGES + 1);
    return (j < rel || j < 0) ? '0 : sh[j];
  endfunction

  task automatic model_clear();
    m_so = 1'b0; m_perr = 1'b0; m_armed = 1'b0; m_aligned = 1'b0; m_lmfc = 1'b0;
    m_sync = '0; m_cnt = 0; m_ref = 0; m_phase = 0;
  endtask

  task automatic model_step();
    int                c;
    int                lat;
    logic              e;
    logic              stable;
    logic [N_SYNC-1:0] w;
    c = cyc;
    if (!reset_b) begin
      model_clear();
      return;
    end
    e   = m_so;
    lat = neg_edge_sel ? SYNC_STAGES + 1 : SYNC_STAGES + 2;
    m_so = hv(c - lat) & ~hv(c - lat - 1);
    if (e && m_cnt < CNT_MAX) m_cnt++;
    // a lane flips once its last DEGLITCH synchronised samples all disagree with it
    for (int i = 0; i < N_SYNC; i++) begin
      stable = 1'b1;
      for (int k = 1; k <= DEGLITCH; k++) begin
        w = ss(c - k);
        if (w[i] == m_sync[i]) stable = 1'b0;
      end
      if (stable) m_sync[i] = ~m_sync[i];
    end
    if (sysref_mode == 2'd0 || sysref_mode == 2'd3) begin
      m_armed = 1'b0; m_aligned = 1'b0;
    end else if (arm) begin
      m_armed = 1'b1; m_aligned = 1'b0; m_perr = 1'b0;
    end else if (m_armed && e) begin
      m_armed = 1'b0; m_aligned = 1'b1; m_ref = c;
    end else if (m_aligned && sysref_mode == 2'd2 && e) begin
      if (m_phase != LMFC_PERIOD - 1) m_perr = 1'b1;
      m_ref = c;
    end
    m_phase = m_aligned ? (c - m_ref) % LMFC_PERIOD : 0;
    m_lmfc  = m_aligned && (m_phase == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 2);
      $fatal(1);
    end
    vh[cyc] = sysref_i;
    sh[cyc] = sync_b_i;
    cyc++;
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_sysref(input int width);
    sysref_i = 1'b1;
    idle(width);
    sysref_i = 1'b0;
  endtask

  // Drive a 4-wide SYSREF pulse and report cycles from drive to sysref_o
  task automatic measure_latency(output int lat);
    int d;
    lat = -1;
    sysref_i = 1'b1;
    d = cyc;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sysref_o && lat < 0) lat = cyc - d;
      if (k == 4) sysref_i = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    check("sync_b_o", sync_b_o, m_sync);
    check("sysref_o", sysref_o, m_so);
    check("lmfc_o", lmfc_o, m_lmfc);
    check("lmfc_phase_o", lmfc_phase_o, m_phase);
    check("aligned_o", aligned_o, m_aligned);
    check("phase_err_o", phase_err_o, m_perr);
    check("sysref_cnt_o", sysref_cnt_o, m_cnt);
  end

  initial begin
    int lat;
    int r;

    // Reset and release with all lanes idle-high
    idle(3);
    reset_b = 1'b1;
    rel = cyc;
    idle(12);
    check("sync_after_release", sync_b_o, 4'hF);

    // Short glitch is filtered, a 3-cycle low propagates
    sync_b_i = 4'hD; idle(2); sync_b_i = 4'hF; idle(8);
    check("glitch_lane1", sync_b_o, 4'hF);
    sync_b_i = 4'hB; idle(3); sync_b_i = 4'hF; idle(4);
    check("lane2_low", sync_b_o, 4'hB);
    idle(6);
    repeat (25) begin
      sync_b_i = N_SYNC'($urandom);
      idle($urandom_range(1, 5));
    end
    sync_b_i = '1;
    idle(10);

    // One-shot alignment
    sysref_mode = 2'd1; idle(2); do_arm(); idle(3);
    measure_latency(lat);
    check("latency_posedge", lat, SYNC_STAGES + 2);
    check("aligned_oneshot", aligned_o, 1'b1);
    pulse_sysref(4); idle(70);
    check("cnt_oneshot", sysref_cnt_o, 2);

    // Continuous mode, in-phase then one shifted edge
    sysref_mode = 2'd2; do_arm(); idle(5);
    repeat (4) begin pulse_sysref(2); idle(62); end
    check("perr_in_phase", phase_err_o, 1'b0);
    idle(5); pulse_sysref(2); idle(20);
    check("perr_shifted", phase_err_o, 1'b1);
    idle(30);
    do_arm();
    check("perr_cleared", phase_err_o, 1'b0);
    idle(3); pulse_sysref(2); idle(40);
    check("cnt_saturated", sysref_cnt_o, CNT_MAX);

    // Negedge capture is one cycle earlier
    sysref_mode = 2'd1; idle(10);
    neg_edge_sel = 1'b1; idle(10);
    do_arm(); idle(3);
    measure_latency(lat);
    check("latency_negedge", lat, SYNC_STAGES + 1);
    idle(40);
    neg_edge_sel = 1'b0; idle(10);

    // Mode exit
    check("aligned_before_exit", aligned_o, 1'b1);
    sysref_mode = 2'd0; tick();
    check("exit_aligned", aligned_o, 1'b0);
    check("exit_lmfc", lmfc_o, 1'b0);
    check("exit_phase", lmfc_phase_o, 0);

    // Randomised mix of modes, arms, SYSREF and SYNC~ activity
    sysref_mode = 2'd2;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) sysref_i = ~sysref_i;
      arm = (r == 50);
      if (r == 60) sysref_mode = 2'($urandom_range(0, 3));
      if (r >= 92) sync_b_i[$urandom_range(0, N_SYNC - 1)] ^= 1'b1;
      tick();
    end
    arm = 1'b0; sysref_i = 1'b0; sync_b_i = '1;
    idle(10);

    // Reset while aligned
    sysref_mode = 2'd1; do_arm(); idle(3); pulse_sysref(3); idle(15);
    check("aligned_before_reset", aligned_o, 1'b1);
    reset_b = 1'b0;
    model_clear();
    #1;
    check("reset_aligned", aligned_o, 1'b0);
    check("reset_sync", sync_b_o, 0);
    check("reset_cnt", sysref_cnt_o, 0);
    idle(3);
    reset_b = 1'b1;
    rel = cyc;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jesd204b_sysref_align.md
Name: jesd204b_sysref_align

Overview:
- Parametrised successor of the JESD204B SYSREF/SYNC~ resynchroniser.
- Captures SYSREF and N SYNC~ lanes on a selectable clock edge, then passes them through a configurable synchroniser depth.
- Deglitches SYNC~ per lane, detects SYSREF rising edges, and aligns a local LMFC counter in one-shot or continuous mode.
- Sits between the board-level SYSREF/SYNC~ pins and the JESD204B RX link layer in the device-clock domain.

Parameters:
- N_SYNC, 4, number of SYNC~ lanes
- SYNC_STAGES, 2, posedge synchroniser flops after the capture flop (min 1)
- LMFC_PERIOD, 32, clk cycles per LMFC period (min 2)
- DEGLITCH, 3, consecutive identical samples required before a SYNC~ lane output changes (min 1)
- CNT_W, 8, width of the SYSREF event counter

Ports:
- clk  in  1  device clock
- reset_b  in  1  async, active-low reset
- neg_edge_sel  in  1  1: capture flop on negedge clk; 0: on posedge clk
- sysref_mode  in  2  0 off, 1 one-shot, 2 continuous, 3 treated as 0
- arm  in  1  single-cycle pulse; starts alignment, clears phase_err_o
- sysref_i  in  1  asynchronous SYSREF
- sync_b_i  in  N_SYNC  asynchronous SYNC~ lanes (active low)
- sync_b_o  out  N_SYNC  synchronised, deglitched SYNC~
- sysref_o  out  1  one-clk pulse per detected SYSREF rising edge
- lmfc_o  out  1  one-clk pulse when LMFC counter == 0 while ALIGNED
- lmfc_phase_o  out  ceil(log2(LMFC_PERIOD))  current LMFC counter
- aligned_o  out  1  state == ALIGNED
- phase_err_o  out  1  sticky: continuous-mode SYSREF arrived off-phase
- sysref_cnt_o  out  CNT_W  saturating count of detected SYSREF edges

Behaviour:
- Reset (reset_b low, async): all flops 0. Therefore sync_b_o = 0 (sync requested), all other outputs 0, state IDLE.
- Capture: one flop on the edge chosen by neg_edge_sel, followed by SYNC_STAGES posedge flops. The result is sysref_s / sync_s. neg_edge_sel is quasi-static; changing it may lose or duplicate one sample.
- Edge detect: sysref_o = sysref_s & ~sysref_s_d (registered). Posedge mode latency: sysref_i high at sampling posedge k gives sysref_o high during cycle k+SYNC_STAGES+1. Negedge mode samples half a cycle earlier.
- sysref_cnt_o increments on every sysref_o, in any mode, and saturates at all-ones.
- SYNC~ deglitch, per lane: a counter runs while sync_s[i] != sync_b_o[i] and resets to 0 when they are equal. When the count reaches DEGLITCH, sync_b_o[i] <= sync_s[i] and the counter clears. DEGLITCH=1 gives a plain pass-through with one extra register.
- State machine, states IDLE, ARMED, ALIGNED:
  - sysref_mode 0 or 3 in any state -> IDLE next cycle. arm is ignored.
  - arm with mode 1 or 2, in any state -> ARMED, phase_err_o <= 0. A sysref edge in the same cycle as arm is not used for alignment; it is still counted.
  - ARMED + sysref edge -> ALIGNED; LMFC counter <= 0 that cycle.
  - ALIGNED, mode 1: later edges do not touch the counter.
  - ALIGNED, mode 2: on an edge, if the counter != LMFC_PERIOD-1 then phase_err_o <= 1. The counter <= 0 either way (realign).
- LMFC counter:
  - Held at 0 in IDLE and ARMED.
  - In ALIGNED, counts 0..LMFC_PERIOD-1 and wraps to 0.
  - lmfc_o = aligned_o & (counter == 0).
  - The first lmfc_o occurs in the cycle after the aligning sysref_o.
- Leaving ALIGNED (mode -> 0): aligned_o falls and the counter returns to 0 next cycle. phase_err_o is held until the next arm or reset.
- Reset mid-operation: immediate return to the reset values above; no partial pulses.

Test Plan:
- Reset then release, sync_b_i=4'hF steady, DEGLITCH=3, SYNC_STAGES=2 -> sync_b_o stays 0 until exactly 3+3 posedges after release, then 4'hF. All other outputs remain 0.
- Glitch: lane 1 low for 2 clk, then lane 2 low for 3 clk -> sync_b_o[1] never changes; sync_b_o[2] goes 0 after the deglitch latency; others stay 1.
- One-shot: mode=1, arm, SYSREF pulse 4 clk wide, posedge capture -> one sysref_o in cycle k+3, aligned_o=1, lmfc_o every 32 clk. A second SYSREF 10 clk later leaves lmfc_phase unchanged; sysref_cnt_o=2.
- Continuous: mode=2, periodic SYSREF every 64 clk -> phase_err_o stays 0. One SYSREF shifted by 5 clk -> phase_err_o=1 and the counter is realigned. A following arm clears phase_err_o.
- Negedge capture: neg_edge_sel=1, SYSREF rising between posedge and negedge -> sysref_o one cycle earlier than with neg_edge_sel=0.
- Saturation and mode exit: CNT_W=2, 5 SYSREF edges -> sysref_cnt_o=3. Set mode=0 while ALIGNED -> aligned_o=0, lmfc_o=0, lmfc_phase_o=0 next cycle.
